// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB-Lite bus enums, slave FSM states and burst helpers
package ahb_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } hresp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    ERR1 = 2'd2,
    ERR2 = 2'd3
  } slave_state_t;

  // Beats in a fixed-length burst; 0 means open-ended (SINGLE/INCR never cancel).
  function automatic logic [4:0] burst_len(input hburst_t b);
    case (b)
      WRAP4, INCR4:   return 5'd4;
      WRAP8, INCR8:   return 5'd8;
      WRAP16, INCR16: return 5'd16;
      default:        return 5'd0;
    endcase
  endfunction

  // Largest depth among up to 32 packed 32-bit region sizes (zero-extended input).
  function automatic int max_words(input logic [1023:0] w);
    int m;
    m = 1;
    for (int i = 0; i < 32; i++) begin
      if (int'(w[i*32 +: 32]) > m) m = int'(w[i*32 +: 32]);
    end
    return m;
  endfunction

endpackage

// File: rtl/ahb_region_decoder.sv
// rtl/ahb_region_decoder.sv - combinational HADDR to region hit, region index and word offset
module ahb_region_decoder #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_BASE  = '0,
  parameter logic [NUM_REGIONS-1:0][31:0]           REGION_WORDS = '0,
  parameter int OFF_W = 4,
  parameter int REG_W = 1
) (
  input  logic [ADDR_WIDTH-1:0] haddr_i,
  output logic                  hit_o,
  output logic [REG_W-1:0]      region_o,
  output logic [OFF_W-1:0]      offset_o
);

  localparam int BYTE_SH = $clog2(DATA_WIDTH/8);

  logic [63:0] rel;

  always_comb begin
    hit_o    = 1'b0;
    region_o = '0;
    offset_o = '0;
    rel      = '0;
    // Scan downwards so the lowest-indexed region wins if ranges overlap.
    for (int r = NUM_REGIONS-1; r >= 0; r--) begin
      rel = 64'(haddr_i) - 64'(REGION_BASE[r]);
      if ((haddr_i >= REGION_BASE[r]) && (rel < (64'(REGION_WORDS[r]) << BYTE_SH))) begin
        hit_o    = 1'b1;
        region_o = REG_W'(r);
        offset_o = OFF_W'(rel >> BYTE_SH);
      end
    end
  end

endmodule

// File: rtl/ahb_lite_slave_mr.sv
// rtl/ahb_lite_slave_mr.sv - multi-region AHB-Lite slave front-end driving a backend strobe interface
// Optional AHB_SLAVE_PRIV_CHECK_EN: unprivileged accesses to PRIV_REGIONS get a two-cycle ERROR.
module ahb_lite_slave_mr
  import ahb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_REGIONS = 2,
  parameter logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0] REGION_BASE = {ADDR_WIDTH'(32'h1000), ADDR_WIDTH'(32'h0)},
  parameter logic [NUM_REGIONS-1:0][31:0] REGION_WORDS = {32'd16, 32'd16},
  parameter logic [NUM_REGIONS-1:0] PRIV_REGIONS = '0,
  localparam int STRB_W    = DATA_WIDTH/8,
  localparam int MAX_WORDS = max_words(1024'(REGION_WORDS)),
  localparam int OFF_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1,
  localparam int REG_W     = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic                  HMASTLOCK,
  input  logic                  HREADY,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [OFF_W-1:0]      addr,
  output logic [REG_W-1:0]      region,
  output logic                  wen,
  output logic                  ren,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [STRB_W-1:0]     wstrb,
  output logic [2:0]            size,
  output logic [2:0]            burst_type,
  output logic [4:0]            burst_count,
  output logic                  burst_cancel,
  input  logic [DATA_WIDTH-1:0] rdata,
  input  logic                  slave_wait
);

  localparam int BYTE_SH = $clog2(STRB_W);

  slave_state_t       state_q, state_d;
  logic [OFF_W-1:0]   addr_q, addr_d;
  logic [REG_W-1:0]   region_q, region_d;
  logic               write_q, write_d;
  logic [2:0]         size_q, size_d, burst_q, burst_d;
  logic [BYTE_SH-1:0] lowaddr_q, lowaddr_d;
  logic [4:0]         count_q, count_d, len_q, len_d;
  logic               open_q, open_d, cancel_q, cancel_d;

  logic                  dec_hit;
  logic [REG_W-1:0]      dec_region;
  logic [OFF_W-1:0]      dec_offset;
  logic                  ready, accept, sample, bad, size_bad, misalign, priv_bad, in_data;
  logic [ADDR_WIDTH-1:0] align_mask;
  htrans_t               trans;
  logic                  unused_ok;

  assign unused_ok = ^{HMASTLOCK, HPROT, PRIV_REGIONS};
  assign trans     = htrans_t'(HTRANS);

  ahb_region_decoder #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH),
    .NUM_REGIONS  (NUM_REGIONS),
    .REGION_BASE  (REGION_BASE),
    .REGION_WORDS (REGION_WORDS),
    .OFF_W        (OFF_W),
    .REG_W        (REG_W)
  ) u_dec (
    .haddr_i  (HADDR),
    .hit_o    (dec_hit),
    .region_o (dec_region),
    .offset_o (dec_offset)
  );

  assign size_bad   = HSIZE > 3'(BYTE_SH);
  assign align_mask = (ADDR_WIDTH'(1) << HSIZE) - ADDR_WIDTH'(1);
  assign misalign   = |(HADDR & align_mask);
`ifdef AHB_SLAVE_PRIV_CHECK_EN
  assign priv_bad   = dec_hit & PRIV_REGIONS[dec_region] & ~HPROT[1];
`else
  assign priv_bad   = 1'b0;
`endif
  assign bad = ~dec_hit | size_bad | misalign | priv_bad;

  always_comb begin
    case (state_q)
      DATA:    ready = ~slave_wait;
      ERR1:    ready = 1'b0;
      default: ready = 1'b1;
    endcase
  end

  // sample marks the address-phase sampling point, whether or not we are selected.
  assign sample = HREADY & ready;
  assign accept = sample & HSEL & HTRANS[1];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    region_d  = region_q;
    write_d   = write_q;
    size_d    = size_q;
    burst_d   = burst_q;
    lowaddr_d = lowaddr_q;
    count_d   = count_q;
    len_d     = len_q;
    open_d    = open_q;
    cancel_d  = 1'b0;

    case (state_q)
      DATA:    if (!slave_wait) state_d = accept ? (bad ? ERR1 : DATA) : IDLE;
      ERR1:    state_d = ERR2;
      default: state_d = accept ? (bad ? ERR1 : DATA) : IDLE;
    endcase

    if (sample && open_q && (!HSEL || trans == TRANS_IDLE || trans == TRANS_NONSEQ)) begin
      cancel_d = 1'b1;
      open_d   = 1'b0;
    end

    if (accept) begin
      addr_d    = dec_offset;
      region_d  = dec_region;
      write_d   = HWRITE;
      size_d    = HSIZE;
      burst_d   = HBURST;
      lowaddr_d = HADDR[BYTE_SH-1:0];
      if (trans == TRANS_NONSEQ) begin
        count_d = 5'd0;
        len_d   = burst_len(hburst_t'(HBURST));
      end else begin
        count_d = count_q + 5'd1;
      end
      open_d = ({1'b0, count_d} + 6'd1) < {1'b0, len_d};
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      region_q  <= '0;
      write_q   <= 1'b0;
      size_q    <= '0;
      burst_q   <= '0;
      lowaddr_q <= '0;
      count_q   <= '0;
      len_q     <= '0;
      open_q    <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      region_q  <= region_d;
      write_q   <= write_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      lowaddr_q <= lowaddr_d;
      count_q   <= count_d;
      len_q     <= len_d;
      open_q    <= open_d;
      cancel_q  <= cancel_d;
    end
  end

  assign in_data      = (state_q == DATA);
  assign wen          = in_data & write_q;
  assign ren          = in_data & ~write_q;
  assign HREADYOUT    = ready;
  assign HRESP        = (state_q == ERR1 || state_q == ERR2) ? ERROR : OKAY;
  assign HRDATA       = (ren && !slave_wait) ? rdata : '0;
  assign wdata        = wen ? HWDATA : '0;
  assign wstrb        = wen ? STRB_W'(((32'd1 << (32'd1 << size_q)) - 32'd1) << lowaddr_q) : '0;
  assign addr         = addr_q;
  assign region       = region_q;
  assign size         = size_q;
  assign burst_type   = burst_q;
  assign burst_count  = count_q;
  assign burst_cancel = cancel_q;

endmodule
